// File: rtl/commit_trace_buffer_if.sv
// Commit-side and drain-side signals of commit_trace_buffer.
// COMMIT_TRACE_TIMESTAMP_EN adds trace_cycle to the drain side.
interface commit_trace_buffer_if #(
  parameter int XLEN      = 32,
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]      commit_valid;
  logic [NUM_PORTS*XLEN-1:0] commit_pc;
  logic [NUM_PORTS*5-1:0]    commit_rd;
  logic [NUM_PORTS-1:0]      commit_we;
  logic [NUM_PORTS*XLEN-1:0] commit_wdata;

  logic                      trace_valid;
  logic                      trace_ready;
  logic [XLEN-1:0]           trace_pc;
  logic [4:0]                trace_rd;
  logic                      trace_we;
  logic [XLEN-1:0]           trace_wdata;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0]               trace_cycle;

  modport master (
    output commit_valid, commit_pc, commit_rd, commit_we, commit_wdata, trace_ready,
    input  trace_valid, trace_pc, trace_rd, trace_we, trace_wdata, trace_cycle
  );
  modport slave (
    input  commit_valid, commit_pc, commit_rd, commit_we, commit_wdata, trace_ready,
    output trace_valid, trace_pc, trace_rd, trace_we, trace_wdata, trace_cycle
  );
`else
  modport master (
    output commit_valid, commit_pc, commit_rd, commit_we, commit_wdata, trace_ready,
    input  trace_valid, trace_pc, trace_rd, trace_we, trace_wdata
  );
  modport slave (
    input  commit_valid, commit_pc, commit_rd, commit_we, commit_wdata, trace_ready,
    output trace_valid, trace_pc, trace_rd, trace_we, trace_wdata
  );
`endif
endinterface

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture FIFO with drain port, counters and cycle-limit stop.
// Optional COMMIT_TRACE_TIMESTAMP_EN stamps each entry with cycle_count.

// Per-port qualification and store decision; rank is the number of
// qualifying commits on lower-indexed ports this cycle.
module commit_trace_lane #(
  parameter int XLEN         = 32,
  parameter int FW           = 5,
  parameter int SKIP_ZERO_PC = 1
) (
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  input  logic            done,
  input  logic [FW-1:0]   rank,
  input  logic [FW-1:0]   space,
  output logic            qual,
  output logic            store
);
  assign qual  = valid && !done && !((SKIP_ZERO_PC != 0) && (pc == '0));
  assign store = qual && (rank < space);
endmodule

module commit_trace_buffer #(
  parameter int XLEN         = 32,
  parameter int NUM_PORTS    = 2,
  parameter int DEPTH        = 16,
  parameter int MAX_CYCLES   = 200,
  parameter int SKIP_ZERO_PC = 1,
  localparam int FW          = $clog2(DEPTH + 1),
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  commit_trace_buffer_if.slave   bus,
  output logic [FW-1:0]          fill_level,
  output logic [31:0]            retire_count,
  output logic [31:0]            drop_count,
  output logic [31:0]            cycle_count,
  output logic                   overflow,
  output logic                   done
);

  typedef struct packed {
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0]     ts;
`endif
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;
  } entry_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  entry_t                      mem [DEPTH];
  entry_t                      wr_ent [NUM_PORTS];
  entry_t                      head;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [NUM_PORTS-1:0]        qual, store;
  logic [NUM_PORTS-1:0][AW-1:0] slot;
  logic [FW-1:0]               rank [NUM_PORTS+1];
  logic [FW-1:0]               space, n_qual, n_store, n_drop;
  logic                        pop;
  logic [31:0]                 cycle_next;

  // Space is fixed at the start of the cycle; a same-cycle pop does not help.
  assign space = FW'(DEPTH) - fill_level;

  always_comb begin
    rank[0] = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      rank[i+1] = rank[i] + FW'(qual[i]);
  end

  assign n_qual  = rank[NUM_PORTS];
  assign n_store = (n_qual < space) ? n_qual : space;
  assign n_drop  = n_qual - n_store;

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_lane
      commit_trace_lane #(
        .XLEN(XLEN), .FW(FW), .SKIP_ZERO_PC(SKIP_ZERO_PC)
      ) u_lane (
        .valid (bus.commit_valid[g]),
        .pc    (bus.commit_pc[g*XLEN +: XLEN]),
        .done  (done),
        .rank  (rank[g]),
        .space (space),
        .qual  (qual[g]),
        .store (store[g])
      );
      // Stored commits occupy consecutive slots in port order.
      assign slot[g] = wr_ptr + rank[g][AW-1:0];
      always_comb begin
        wr_ent[g]       = '0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        wr_ent[g].ts    = cycle_count;
`endif
        wr_ent[g].pc    = bus.commit_pc[g*XLEN +: XLEN];
        wr_ent[g].rd    = bus.commit_rd[g*5 +: 5];
        wr_ent[g].we    = bus.commit_we[g];
        wr_ent[g].wdata = bus.commit_wdata[g*XLEN +: XLEN];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++)
      if (store[i]) mem[slot[i]] <= wr_ent[i];
  end

  assign head            = mem[rd_ptr];
  assign bus.trace_valid = (fill_level != '0);
  assign bus.trace_pc    = head.pc;
  assign bus.trace_rd    = head.rd;
  assign bus.trace_we    = head.we;
  assign bus.trace_wdata = head.wdata;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  assign bus.trace_cycle = head.ts;
`endif

  assign pop        = bus.trace_valid && bus.trace_ready;
  assign cycle_next = sat_add(cycle_count, 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      retire_count <= '0;
      drop_count   <= '0;
      cycle_count  <= '0;
      overflow     <= 1'b0;
      done         <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + AW'(n_store);
      rd_ptr       <= rd_ptr + AW'(pop);
      fill_level   <= fill_level + n_store - FW'(pop);
      cycle_count  <= cycle_next;
      retire_count <= sat_add(retire_count, 32'(n_qual));
      drop_count   <= sat_add(drop_count, 32'(n_drop));
      if (n_drop != '0) overflow <= 1'b1;
      if ((MAX_CYCLES != 0) && (cycle_next == 32'(MAX_CYCLES))) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (default parameters).
module tb_commit_trace_buffer;
  localparam int XLEN = 32;
  localparam int NP   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  fill_level;
  logic [31:0] retire_count, drop_count, cycle_count;
  logic        overflow, done;
  int          checks = 0;
  int          failures = 0;

  commit_trace_buffer_if #(.XLEN(XLEN), .NUM_PORTS(NP)) bus ();

  commit_trace_buffer #(
    .XLEN(XLEN), .NUM_PORTS(NP), .DEPTH(16), .MAX_CYCLES(200), .SKIP_ZERO_PC(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .fill_level   (fill_level),
    .retire_count (retire_count),
    .drop_count   (drop_count),
    .cycle_count  (cycle_count),
    .overflow     (overflow),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.commit_valid = '0;
    bus.commit_pc    = '0;
    bus.commit_rd    = '0;
    bus.commit_we    = '0;
    bus.commit_wdata = '0;
  endtask

  task automatic set_port(input int p, input logic [31:0] pc, input logic [4:0] rd,
                          input logic we, input logic [31:0] wd);
    bus.commit_valid[p]            = 1'b1;
    bus.commit_pc[p*XLEN +: XLEN]  = pc;
    bus.commit_rd[p*5 +: 5]        = rd;
    bus.commit_we[p]               = we;
    bus.commit_wdata[p*XLEN +: XLEN] = wd;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clr();
    bus.trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    clr();
    bus.trace_ready = 1'b0;
    do_reset();

    // reset state
    chk("rst_valid", 64'(bus.trace_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_retire", 64'(retire_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_cycle", 64'(cycle_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // single commit
    set_port(0, 32'h4, 5'd5, 1'b1, 32'h2A);
    tick();
    clr();
    chk("t1_valid", 64'(bus.trace_valid), 64'd1);
    chk("t1_pc", 64'(bus.trace_pc), 64'h4);
    chk("t1_rd", 64'(bus.trace_rd), 64'd5);
    chk("t1_we", 64'(bus.trace_we), 64'd1);
    chk("t1_wdata", 64'(bus.trace_wdata), 64'h2A);
    chk("t1_fill", 64'(fill_level), 64'd1);
    chk("t1_retire", 64'(retire_count), 64'd1);
    chk("t1_cycle", 64'(cycle_count), 64'd1);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    chk("t1_ts", 64'(bus.trace_cycle), 64'd0);
`endif
    bus.trace_ready = 1'b1;
    tick();
    chk("t1_pop_fill", 64'(fill_level), 64'd0);
    chk("t1_pop_valid", 64'(bus.trace_valid), 64'd0);

    // two commits in one cycle, port order preserved
    bus.trace_ready = 1'b0;
    set_port(0, 32'h8, 5'd1, 1'b1, 32'h11);
    set_port(1, 32'hC, 5'd2, 1'b0, 32'h22);
    tick();
    clr();
    chk("t2_fill", 64'(fill_level), 64'd2);
    chk("t2_pc0", 64'(bus.trace_pc), 64'h8);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    chk("t2_ts0", 64'(bus.trace_cycle), 64'd2);
`endif
    bus.trace_ready = 1'b1;
    tick();
    chk("t2_pc1", 64'(bus.trace_pc), 64'hC);
    chk("t2_we1", 64'(bus.trace_we), 64'd0);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    chk("t2_ts1", 64'(bus.trace_cycle), 64'd2);
`endif
    tick();
    chk("t2_fill_end", 64'(fill_level), 64'd0);
    bus.trace_ready = 1'b0;

    // pc == 0 is a bubble
    set_port(0, 32'h0, 5'd3, 1'b1, 32'h33);
    tick();
    clr();
    chk("t3_valid", 64'(bus.trace_valid), 64'd0);
    chk("t3_retire", 64'(retire_count), 64'd3);
    chk("t3_fill", 64'(fill_level), 64'd0);

    // fill to DEPTH, then overflow
    do_reset();
    for (int c = 0; c < 9; c++) begin
      set_port(0, 32'(4 * (2 * c + 1)), 5'd1, 1'b1, 32'(c));
      set_port(1, 32'(4 * (2 * c + 2)), 5'd2, 1'b1, 32'(c));
      tick();
    end
    clr();
    chk("t4_fill", 64'(fill_level), 64'd16);
    chk("t4_drop", 64'(drop_count), 64'd2);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_retire", 64'(retire_count), 64'd18);
    chk("t4_head", 64'(bus.trace_pc), 64'h4);

    // full + pop + commit in same cycle: commit dropped
    bus.trace_ready = 1'b1;
    set_port(0, 32'h100, 5'd7, 1'b1, 32'h77);
    tick();
    clr();
    chk("t5_drop", 64'(drop_count), 64'd3);
    chk("t5_fill", 64'(fill_level), 64'd15);
    chk("t5_retire", 64'(retire_count), 64'd19);
    for (int j = 0; j < 15; j++) begin
      chk($sformatf("t5_drain%0d", j), 64'(bus.trace_pc), 64'(8 + 4 * j));
      tick();
    end
    chk("t5_empty_fill", 64'(fill_level), 64'd0);
    chk("t5_empty_valid", 64'(bus.trace_valid), 64'd0);
    bus.trace_ready = 1'b0;

    // cycle limit
    do_reset();
    for (int n = 1; n <= 200; n++) begin
      set_port(0, 32'(4 * n), 5'd1, 1'b1, 32'(n));
      tick();
      if (n == 199) chk("t6_done_early", 64'(done), 64'd0);
    end
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_cycle", 64'(cycle_count), 64'd200);
    chk("t6_retire", 64'(retire_count), 64'd200);
    chk("t6_drop", 64'(drop_count), 64'd184);
    chk("t6_fill", 64'(fill_level), 64'd16);
    set_port(0, 32'h9000, 5'd1, 1'b1, 32'h1);
    repeat (5) tick();
    clr();
    chk("t6_retire_frozen", 64'(retire_count), 64'd200);
    chk("t6_drop_frozen", 64'(drop_count), 64'd184);
    chk("t6_fill_frozen", 64'(fill_level), 64'd16);
    bus.trace_ready = 1'b1;
    repeat (3) tick();
    chk("t6_drain_fill", 64'(fill_level), 64'd13);
    chk("t6_drain_head", 64'(bus.trace_pc), 64'h10);

    // asynchronous reset mid-drain
    reset = 1'b0;
    #1;
    chk("t7_fill", 64'(fill_level), 64'd0);
    chk("t7_retire", 64'(retire_count), 64'd0);
    chk("t7_drop", 64'(drop_count), 64'd0);
    chk("t7_cycle", 64'(cycle_count), 64'd0);
    chk("t7_done", 64'(done), 64'd0);
    chk("t7_ovf", 64'(overflow), 64'd0);
    chk("t7_valid", 64'(bus.trace_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable retire-trace capture block for the pipelined RISC-V core.
- Sits beside the CPU at the MEM/WB boundary and captures up to NUM_PORTS retired instructions per cycle (pc, rd, write data) into a circular FIFO.
- Provides a valid/ready drain port, retire/cycle/drop counters and a sticky cycle-limit stop, so benches and debug logic read commit order from hardware rather than probing internal registers.

Parameters:
- XLEN, 32, data/pc width
- NUM_PORTS, 2, commit ports per cycle (1..4)
- DEPTH, 16, FIFO entries; power of two, >= NUM_PORTS
- MAX_CYCLES, 200, cycle limit after which capture stops; 0 = unlimited
- SKIP_ZERO_PC, 1, 1 = commits with pc == 0 are treated as bubbles and ignored

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- commit_valid  in  NUM_PORTS  per-port retire strobe
- commit_pc  in  NUM_PORTS*XLEN  retired pc; port i occupies bits [i*XLEN +: XLEN]
- commit_rd  in  NUM_PORTS*5  destination register index
- commit_we  in  NUM_PORTS  register-write flag
- commit_wdata  in  NUM_PORTS*XLEN  written value
- trace_valid  out  1  head entry available
- trace_ready  in  1  consumer pops head
- trace_pc  out  XLEN  head pc
- trace_rd  out  5  head rd
- trace_we  out  1  head write flag
- trace_wdata  out  XLEN  head write data
- fill_level  out  $clog2(DEPTH+1)  occupied entries
- retire_count  out  32  qualifying commits seen
- drop_count  out  32  qualifying commits not stored
- cycle_count  out  32  cycles since reset release
- overflow  out  1  sticky: at least one drop occurred
- done  out  1  sticky: cycle limit reached

Behaviour:
- Reset (reset low, asynchronous): pointers = 0; fill_level = 0; all counters = 0; overflow = 0; done = 0; trace_valid = 0. Trace data outputs are don't-care while trace_valid = 0.
- Qualifying commit: commit_valid[i] && !done && !(SKIP_ZERO_PC && commit_pc[i] == 0).
- Ordering: qualifying commits in one cycle are written in ascending port index, one consecutive slot each.
- Space: computed as DEPTH - fill_level at the start of the cycle. A pop in the same cycle does not free space for that cycle's writes.
- Full FIFO: with k qualifying commits and s free slots, the lowest-indexed min(k,s) commits are stored and the rest are dropped. drop_count += k - min(k,s); overflow is set if any commit is dropped.
- Counters: retire_count += k every cycle, including dropped commits.
- Pop: occurs when trace_valid && trace_ready. Head data is a combinational read at the read pointer.
- Latency: an entry written at edge N is visible at the head (when the FIFO was empty) in the cycle after edge N. trace_valid = (fill_level != 0).
- fill_level: next value = fill_level + stored - popped. Pointers wrap modulo DEPTH.
- trace_ready while empty: no effect.
- cycle_count: increments every cycle after reset release and saturates at 0xFFFFFFFF. retire_count and drop_count also saturate.
- done: set on the edge where cycle_count reaches MAX_CYCLES (when MAX_CYCLES != 0). Sticky until reset.
- After done: no new captures and retire_count freezes; draining continues normally.
- Reset asserted mid-drain or mid-capture: all state clears immediately; FIFO contents are discarded.

Optional Feature:
- Macro: COMMIT_TRACE_TIMESTAMP_EN.
- Defined: extra output trace_cycle (32 bits) carries the cycle_count value sampled when the head entry was written. Each FIFO entry widens by 32 bits, and same-cycle commits share the same stamp.
- Undefined: the port and storage are absent; all other behaviour is identical.

Test Plan:
- Reset, then single-port commit pc=0x4, rd=5, we=1, wdata=0x2A, trace_ready=0 -> next cycle trace_valid=1, trace_pc=0x4, trace_rd=5, trace_wdata=0x2A, fill_level=1, retire_count=1.
- Same cycle: port0 pc=0x8 and port1 pc=0xC -> after two pops the order is 0x8 then 0xC; fill_level returns to 0.
- Commit pc=0x0 with SKIP_ZERO_PC=1 -> nothing stored; retire_count unchanged; trace_valid stays 0.
- DEPTH=16, ready held 0: 8 cycles of 2 commits, then one cycle with 2 commits -> fill_level=16, drop_count=2, overflow=1, retire_count=18. Draining yields the first 16 pcs in order.
- FIFO full with a pop and 1 commit in the same cycle -> the commit is dropped (drop_count+1) and fill_level=15.
- MAX_CYCLES=200 with continuous commits -> done=1 when cycle_count=200. Later commits are not stored and retire_count is frozen; asserting reset low mid-drain clears fill_level, counters and done to 0.
